// File: rtl/uart_pkg.sv
// uart_pkg: shared constants for the decimal-ASCII UART transmitter
//   Top-level sequencer states (ST_*), per-frame serialiser states (S_*),
//   ASCII codes for the digit base and line ending, and the baud divider helper.
package uart_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CONV  = 2'd1;
    localparam logic [1:0] ST_NEXT  = 2'd2;
    localparam logic [1:0] ST_FRAME = 2'd3;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    function automatic int baud_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_dec_tx_if.sv
// uart_dec_tx_if: byte handshake between the application and the transmitter
//   tx_data  [7:0] byte to send
//   tx_valid       tx_data is valid
//   tx_ready       transmitter can accept a byte
//   busy           a message is in progress
interface uart_dec_tx_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;

    modport master (output tx_data, tx_valid, input tx_ready, busy);
    modport slave  (input tx_data, tx_valid, output tx_ready, busy);

endinterface

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: one-frame UART serialiser (start, 8 data bits LSB first, [parity], stop)
//   clk, rst_n  clock, asynchronous active-low reset
//   start       pulse while idle launches a frame carrying tx_byte
//   tx_byte     character to send, captured on the start edge
//   done        high during the final clock of the stop bit
//   tx          serial line, idles high
//   UART_DEC_TX_PARITY_EN adds an even-parity bit after the data bits.
module uart_tx_byte
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = 5208
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] tx_byte,
    output logic       done,
    output logic       tx
);

    localparam int CW = $clog2(BAUD_DIV);

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    data;
    logic          last;
`ifdef UART_DEC_TX_PARITY_EN
    logic          par;
`endif

    assign last = cnt == CW'(BAUD_DIV - 1);
    assign done = state == S_STOP && last;

    // tx is registered so an asynchronous reset forces the line high at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            data    <= '0;
            tx      <= 1'b1;
`ifdef UART_DEC_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            cnt <= (state == S_IDLE || last) ? '0 : cnt + 1'b1;
            case (state)
                S_IDLE: if (start) begin
                    state   <= S_START;
                    data    <= tx_byte;
                    bit_idx <= '0;
                    tx      <= 1'b0;
`ifdef UART_DEC_TX_PARITY_EN
                    par     <= ^tx_byte;
`endif
                end
                S_START: if (last) begin
                    state <= S_DATA;
                    tx    <= data[0];
                end
                // data shifts right so the next bit is always data[1]
                S_DATA: if (last) begin
                    if (bit_idx == 3'd7) begin
`ifdef UART_DEC_TX_PARITY_EN
                        state <= S_PARITY;
                        tx    <= par;
`else
                        state <= S_STOP;
                        tx    <= 1'b1;
`endif
                    end else begin
                        bit_idx <= bit_idx + 3'd1;
                        data    <= {1'b0, data[7:1]};
                        tx      <= data[1];
                    end
                end
`ifdef UART_DEC_TX_PARITY_EN
                S_PARITY: if (last) begin
                    state <= S_STOP;
                    tx    <= 1'b1;
                end
`endif
                S_STOP: if (last) state <= S_IDLE;
                default: begin
                    state <= S_IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_dec_tx.sv
// uart_dec_tx: UART transmitter sending each accepted byte as three decimal digits plus CR LF
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         slave side of uart_dec_tx_if (tx_data, tx_valid, tx_ready, busy)
//   tx          serial line, idles high
//   CLK_FREQ/BAUD set the bit time; CLK_FREQ/BAUD must be >= 2.
//   UART_DEC_TX_PARITY_EN selects 11-bit frames with even parity.
module uart_dec_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_dec_tx_if.slave   bus,
    output logic           tx
);

    localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD);

    logic [1:0] state;
    logic [7:0] data;
    logic [1:0] hund;
    logic [3:0] tens;
    logic [3:0] ones;
    logic [2:0] idx;
    logic [7:0] chr;
    logic       start;
    logic       done;

    assign bus.tx_ready = state == ST_IDLE;
    assign bus.busy     = state != ST_IDLE;
    assign start        = state == ST_NEXT;

    assign chr = idx == 3'd0 ? ASCII_0 + {6'd0, hund} :
                 idx == 3'd1 ? ASCII_0 + {4'd0, tens} :
                 idx == 3'd2 ? ASCII_0 + {4'd0, ones} :
                 idx == 3'd3 ? ASCII_CR : ASCII_LF;

    // The frame-done edge both ends the stop bit and picks the next step, so
    // the single NEXT cycle stretches every inner stop bit to BAUD_DIV+1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            data  <= '0;
            hund  <= '0;
            tens  <= '0;
            ones  <= '0;
            idx   <= '0;
        end else begin
            case (state)
                ST_IDLE: if (bus.tx_valid) begin
                    data  <= bus.tx_data;
                    state <= ST_CONV;
                end
                ST_CONV: begin
                    hund  <= 2'(data / 8'd100);
                    tens  <= 4'((data / 8'd10) % 8'd10);
                    ones  <= 4'(data % 8'd10);
                    idx   <= '0;
                    state <= ST_NEXT;
                end
                ST_NEXT: state <= ST_FRAME;
                ST_FRAME: if (done) begin
                    if (idx == 3'd4) state <= ST_IDLE;
                    else begin
                        idx   <= idx + 3'd1;
                        state <= ST_NEXT;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    uart_tx_byte #(.BAUD_DIV(BAUD_DIV)) u_byte (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .tx_byte (chr),
        .done    (done),
        .tx      (tx)
    );

endmodule

// File: tb/tb_uart_dec_tx.sv
// tb_uart_dec_tx: scoreboard bench for uart_dec_tx with a mid-bit UART receiver
module tb_uart_dec_tx;

    localparam int CLK_FREQ = 1000;
    localparam int BAUD     = 100;
    localparam int DIV      = CLK_FREQ / BAUD;
`ifdef UART_DEC_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int MSG_LEN = 6 + 5 * NB * DIV;
    localparam int LIMIT   = 4 * MSG_LEN;

    typedef struct {
        logic [10:0] frame;
        int          fall;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic tx;

    uart_dec_tx_if bus();

    uart_dec_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .tx    (tx)
    );

    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   n_acc = 0;
    int   n_rx = 0;
    int   ready_due = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: byte d on the wire is the text of d as three decimal digits then CR LF;
    // first start bit 2 clocks after the accepting edge, frames NB*DIV+1 clocks apart.
    function automatic void push_msg(input logic [7:0] d, input int h);
        string      s;
        logic [7:0] c;
        exp_t       e;
        s = {$sformatf("%0d", 1000 + int'(d)), "\r\n"};
        for (int k = 0; k < 5; k++) begin
            c = s[k + 1];
`ifdef UART_DEC_TX_PARITY_EN
            e.frame = {1'b1, ^c, c, 1'b0};
`else
            e.frame = {2'b11, c, 1'b0};
`endif
            e.fall = h + 2 + k * (NB * DIV + 1);
            exp_q.push_back(e);
        end
    endfunction

    // Handshake side: check ready/busy against the message timeline, push accepted bytes.
    initial begin : hs_mon
        logic exp_rdy;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                exp_rdy = cyc >= ready_due;
                n_vec++;
                if ({bus.tx_ready, bus.busy} !== {exp_rdy, ~exp_rdy}) begin
                    n_err++;
                    $display("FAIL ready @%0d: ready,busy=%b%b want %b%b", cyc, bus.tx_ready, bus.busy, exp_rdy, ~exp_rdy);
                end
                if (bus.tx_valid && bus.tx_ready) begin
                    push_msg(bus.tx_data, cyc + 1);
                    ready_due = cyc + 1 + MSG_LEN;
                    n_acc++;
                end
            end
        end
    end

    // Line side: receive frames at mid-bit and compare with the scoreboard.
    initial begin : rx_mon
        int          cnt;
        int          fall;
        logic [10:0] sh;
        exp_t        e;
        cnt  = -1;
        fall = 0;
        sh   = '1;
        forever begin
            @(negedge clk);
            if (!rst_n) cnt = -1;
            else if (cnt < 0) begin
                if (tx === 1'b0) begin
                    cnt  = 0;
                    fall = cyc;
                    sh   = '1;
                end
            end else begin
                cnt++;
                if (cnt % DIV == DIV / 2) sh[cnt / DIV] = tx;
                if (cnt == DIV / 2 + (NB - 1) * DIV) begin
                    cnt = -1;
                    n_rx++;
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL rx: unexpected frame %b falling at %0d", sh, fall);
                    end else begin
                        e = exp_q.pop_front();
                        if (sh !== e.frame) begin
                            n_err++;
                            $display("FAIL frame: got %b want %b", sh, e.frame);
                        end
                        n_vec++;
                        if (fall != e.fall) begin
                            n_err++;
                            $display("FAIL start edge: cycle %0d want %0d", fall, e.fall);
                        end
                    end
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [7:0] d);
        @(posedge clk);
        #2;
        bus.tx_valid = v;
        bus.tx_data  = d;
    endtask

    task automatic wait_acc(input int n);
        int i = 0;
        while (n_acc < n && i < LIMIT) begin
            @(posedge clk);
            i++;
        end
        n_vec++;
        if (n_acc < n) begin
            n_err++;
            $display("FAIL handshake: accepted %0d want %0d", n_acc, n);
        end
    endtask

    task automatic send(input logic [7:0] d);
        int n = n_acc;
        drive(1'b1, d);
        wait_acc(n + 1);
        drive(1'b0, 8'd0);
    endtask

    task automatic send_pair(input logic [7:0] a, input logic [7:0] b);
        int n = n_acc;
        drive(1'b1, a);
        wait_acc(n + 1);
        drive(1'b1, b);
        wait_acc(n + 2);
        drive(1'b0, 8'd0);
    endtask

    task automatic wait_idle();
        int i = 0;
        while ((exp_q.size() != 0 || cyc < ready_due) && i < LIMIT) begin
            @(posedge clk);
            i++;
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d chars still expected", exp_q.size());
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic check_idle(input string name);
        n_vec++;
        if ({tx, bus.tx_ready, bus.busy} !== 3'b110) begin
            n_err++;
            $display("FAIL %s: tx,ready,busy=%b%b%b want 110", name, tx, bus.tx_ready, bus.busy);
        end
    endtask

    initial begin
        int base;
        int i;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'd0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_idle("reset");
        #1 rst_n = 1'b1;
        send(8'd0);
        wait_idle();
        send(8'd255);
        wait_idle();
        send_pair(8'd107, 8'd9);
        wait_idle();
        base = n_rx;
        send(8'd200);
        i = 0;
        while (n_rx == base && i < LIMIT) begin
            @(posedge clk);
            i++;
        end
        repeat (5 * DIV + 1) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_idle("async reset");
        exp_q.delete();
        ready_due = 0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        send(8'd5);
        wait_idle();
        send_pair(8'd1, 8'd2);
        wait_idle();
        for (int k = 0; k < 4; k++) begin
            send(8'($urandom_range(0, 255)));
            repeat ($urandom_range(0, 20)) @(posedge clk);
        end
        wait_idle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
